irq_vector_dispatch: RTL and testbench
======================================

# irq_vector_dispatch

Sequential dispatch stage placed directly downstream of the combinational 27-channel priority interrupt encoder (three 9-channel buses, bus 0 highest priority). It takes the encoder's per-bus request flags and winning channel index, qualifies them over two clocks to filter combinational glitches, and presents one vector to the CPU with a request/acknowledge handshake. It also tracks nested in-service levels with end-of-interrupt (EOI) handling, and times out unacknowledged requests.

## Interface
- NUM_BUS, 3: number of request buses; index 0 is highest priority.
- CHAN_W, 4: channel index width.
- MAX_CHAN, 8: highest legal channel index; larger values are invalid.
- ACK_TO, 16: maximum number of cycles `irq_o` waits for `ack_i`; must be ≥ 2.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_req_i  in  NUM_BUS  encoder per-bus request flags.
- chan_i  in  CHAN_W  encoder's winning channel, belonging to the highest-priority asserted bus.
- ack_i  in  1  CPU acknowledge; sampled only in state REQ.
- eoi_i  in  1  end of interrupt; pops the top in-service level.
- irq_o  out  1  interrupt request to the CPU.
- vec_o  out  2+CHAN_W  {bus index, channel}; stable while `irq_o`=1.
- in_service_o  out  NUM_BUS  in-service bus mask.
- spurious_o  out  1  one-cycle pulse on ack timeout.
- eoi_err_o  out  1  one-cycle pulse when EOI arrives with nothing in service.

## Operation
- Candidate: b = lowest index with bus_req_i[b]=1, and c = chan_i.
- A candidate is eligible when c ≤ MAX_CHAN and b < lowest set bit of in_service (or in_service=0). Same-priority and lower-priority requests are blocked.
- FSM states: IDLE, QUAL, REQ.
  - IDLE: on an eligible candidate, latch (b,c) and go to QUAL.
  - QUAL: if the same (b,c) is present and still eligible, go to REQ, set irq_o=1 and vec_o={b,c}. Otherwise return to IDLE with no output.
  - REQ: on ack_i, set in_service[b], store c in chan_store[b], clear irq_o, go to IDLE. If the timeout counter reaches ACK_TO-1 without ack, clear irq_o, pulse spurious_o, go to IDLE.
- In-service stack: the in_service mask plus chan_store[NUM_BUS]. No pointer is needed, because every push is strictly higher priority than everything already in service. The top of stack is the lowest set bit.
- EOI is honoured in any state:
  - It clears the lowest set bit of in_service.
  - If in_service=0, it pulses eoi_err_o and changes nothing else.
- ack_i and eoi_i in the same edge while in REQ: the pop applies to the pre-existing mask first, then the push.
- A bus_req_i change during REQ does not alter vec_o. The latched request is delivered or times out.
- Reset values: state IDLE; irq_o, vec_o, in_service_o, spurious_o, eoi_err_o, timeout counter and chan_store all 0. A reset mid-REQ drops irq_o at the next edge.

## Timing
- Latency: input stable before edge E0 gives QUAL after E0 and irq_o=1 after E1. Minimum latency is 2 cycles.
- irq_o stays high for at most ACK_TO cycles. The timeout counter clears on entry to REQ.
- An ack at edge Ea drops irq_o after Ea and updates in_service_o at the same edge. The earliest re-assertion for a higher-priority request is 2 cycles after Ea.
- EOI takes effect on the mask at the same edge it is sampled.
- spurious_o and eoi_err_o are registered, one cycle wide.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package irq_pkg holds NUM_BUS, CHAN_W, MAX_CHAN, the state enum (IDLE, QUAL, REQ), and the vector struct {bus, chan}.
- Sub-module irq_isr_stack holds the in_service mask, chan_store and the push/pop/top-of-stack logic, including the same-edge pop-then-push rule.
- The top level holds the qualification FSM, the timeout counter and the output registers.

## Test plan
- Request ack, no nesting: after reset, hold bus_req_i=3'b010, chan_i=5. irq_o rises 2 cycles later with vec_o=6'b01_0101. Ack gives irq_o=0 and in_service_o=3'b010.
- Glitch filter: bus_req_i=3'b001, chan_i=3 for one cycle only. irq_o stays 0 and the FSM returns to IDLE.
- Nesting and EOI errors: start with bus 2 chan 7 in service, then request bus 0 chan 1. Expect vec_o=6'b00_0001; ack gives in_service=3'b101. The first EOI gives 3'b100, the second gives 3'b000, the third pulses eoi_err_o.
- Priority blocking and invalid channel: with bus 1 in service, requests on bus 1 or bus 2 raise no irq. A bus-0 request with chan_i=12 raises no irq.
- Timeout: with ACK_TO=4 and no ack, irq_o is high exactly 4 cycles, spurious_o pulses once, and a persistent request re-qualifies 2 cycles later.
- Simultaneous events and reset: with in_service=3'b100 and a bus-0 request in REQ, drive ack_i and eoi_i together; in_service becomes 3'b001. Asserting rst mid-REQ zeroes all outputs at the next edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt vector dispatch stage.
package irq_pkg;
  localparam int NUM_BUS  = 3;
  localparam int CHAN_W   = 4;
  localparam int MAX_CHAN = 8;
  localparam int BUS_W    = 2;

  typedef enum logic [1:0] {IDLE, QUAL, REQ} state_e;

  typedef struct packed {
    logic [BUS_W-1:0]  bus;
    logic [CHAN_W-1:0] chan;
  } vec_t;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [BUS_W-1:0] lowest_idx(input logic [NUM_BUS-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_BUS - 1; i >= 0; i--)
      if (m[i]) lowest_idx = BUS_W'(i);
  endfunction

  // True when any in-service level has priority equal to or above bus b.
  function automatic logic blocked(input logic [NUM_BUS-1:0] ism,
                                   input logic [BUS_W-1:0]   b);
    blocked = 1'b0;
    for (int i = 0; i < NUM_BUS; i++)
      if (ism[i] && (BUS_W'(i) <= b)) blocked = 1'b1;
  endfunction
endpackage

// File: rtl/irq_isr_stack.sv
// In-service level tracking: mask plus per-bus channel store, top of stack
// is the lowest set bit. Pops see the old mask before a same-edge push.
module irq_isr_stack
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  vec_t               push_vec_i,
  input  logic               pop_i,
  output logic [NUM_BUS-1:0] mask_o,
  output logic               err_o
);
  logic [NUM_BUS-1:0]             mask_q, mask_d;
  logic [NUM_BUS-1:0][CHAN_W-1:0] store_q, store_d;
  logic                           err_q, err_d;

  always_comb begin
    mask_d  = mask_q;
    store_d = store_q;
    err_d   = 1'b0;
    if (pop_i) begin
      if (mask_q == '0) err_d = 1'b1;
      else              mask_d = mask_q & (mask_q - 1'b1);
    end
    if (push_i) begin
      mask_d[push_vec_i.bus]  = 1'b1;
      store_d[push_vec_i.bus] = push_vec_i.chan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      store_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  assign mask_o = mask_q;
  assign err_o  = err_q;
endmodule

// File: rtl/irq_vector_dispatch.sv
// Two-cycle glitch qualification of encoder output, CPU req/ack handshake
// with ack timeout, and nested in-service tracking with EOI.
module irq_vector_dispatch
  import irq_pkg::*;
#(
  parameter int ACK_TO = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BUS-1:0]    bus_req_i,
  input  logic [CHAN_W-1:0]     chan_i,
  input  logic                  ack_i,
  input  logic                  eoi_i,
  output logic                  irq_o,
  output logic [BUS_W+CHAN_W-1:0] vec_o,
  output logic [NUM_BUS-1:0]    in_service_o,
  output logic                  spurious_o,
  output logic                  eoi_err_o
);
  localparam int CNT_W = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TO - 1);

  state_e             state_q, state_d;
  vec_t               cand_q, cand_d, vec_q, vec_d, cand;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d, spur_q, spur_d;
  logic               push, elig;
  logic [NUM_BUS-1:0] is_mask;

  assign cand.bus  = lowest_idx(bus_req_i);
  assign cand.chan = chan_i;
  assign elig = (|bus_req_i) && (chan_i <= CHAN_W'(MAX_CHAN)) && !blocked(is_mask, cand.bus);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    spur_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (elig) begin
        cand_d  = cand;
        state_d = QUAL;
      end
      QUAL: if (elig && (cand == cand_q)) begin
        state_d = REQ;
        irq_d   = 1'b1;
        vec_d   = cand_q;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
      REQ: if (ack_i) begin
        push    = 1'b1;
        irq_d   = 1'b0;
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        irq_d   = 1'b0;
        spur_d  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      spur_q  <= spur_d;
    end
  end

  irq_isr_stack u_stack (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_vec_i (vec_q),
    .pop_i      (eoi_i),
    .mask_o     (is_mask),
    .err_o      (eoi_err_o)
  );

  assign irq_o        = irq_q;
  assign vec_o        = vec_q;
  assign in_service_o = is_mask;
  assign spurious_o   = spur_q;
endmodule

// File: tb/tb_irq_vector_dispatch.sv
// Directed bench for irq_vector_dispatch with ACK_TO=4.
module tb_irq_vector_dispatch;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] bus_req_i;
  logic [3:0] chan_i;
  logic       ack_i, eoi_i;
  logic       irq_o, spurious_o, eoi_err_o;
  logic [5:0] vec_o;
  logic [2:0] in_service_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_vector_dispatch #(.ACK_TO(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_req_i    (bus_req_i),
    .chan_i       (chan_i),
    .ack_i        (ack_i),
    .eoi_i        (eoi_i),
    .irq_o        (irq_o),
    .vec_o        (vec_o),
    .in_service_o (in_service_o),
    .spurious_o   (spurious_o),
    .eoi_err_o    (eoi_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_irq"}, {7'd0, irq_o}, 8'd0);
    chk({tag, "_vec"}, {2'd0, vec_o}, 8'd0);
    chk({tag, "_is"}, {5'd0, in_service_o}, 8'd0);
    chk({tag, "_spur"}, {7'd0, spurious_o}, 8'd0);
    chk({tag, "_eerr"}, {7'd0, eoi_err_o}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; bus_req_i = '0; chan_i = '0; ack_i = 1'b0; eoi_i = 1'b0;
    step(); step();
    rst = 1'b0;
    outs_zero("reset");

    // Basic request/ack on bus 1 chan 5
    bus_req_i = 3'b010; chan_i = 4'd5;
    step(); chk("t1_qual_irq", {7'd0, irq_o}, 8'd0);
    step(); chk("t1_irq", {7'd0, irq_o}, 8'd1);
    chk("t1_vec", {2'd0, vec_o}, 8'b01_0101);
    ack_i = 1'b1; step(); ack_i = 1'b0; bus_req_i = '0;
    chk("t1_ack_irq", {7'd0, irq_o}, 8'd0);
    chk("t1_ack_is", {5'd0, in_service_o}, 8'b010);
    eoi_i = 1'b1; step(); eoi_i = 1'b0;
    chk("t1_eoi_is", {5'd0, in_service_o}, 8'b000);

    // One-cycle glitch is filtered
    bus_req_i = 3'b001; chan_i = 4'd3;
    step(); bus_req_i = '0;
    step(); chk("glitch_irq0", {7'd0, irq_o}, 8'd0);
    step(); chk("glitch_irq1", {7'd0, irq_o}, 8'd0);

    // Nesting: bus 2 chan 7, then bus 0 chan 1
    bus_req_i = 3'b100; chan_i = 4'd7;
    step(); step();
    chk("n_vec2", {2'd0, vec_o}, 8'b10_0111);
    ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("n_is100", {5'd0, in_service_o}, 8'b100);
    bus_req_i = 3'b001; chan_i = 4'd1;
    step(); step();
    chk("n_irq0", {7'd0, irq_o}, 8'd1);
    chk("n_vec0", {2'd0, vec_o}, 8'b00_0001);
    ack_i = 1'b1; step(); ack_i = 1'b0; bus_req_i = '0;
    chk("n_is101", {5'd0, in_service_o}, 8'b101);
    eoi_i = 1'b1;
    step(); chk("n_eoi1", {5'd0, in_service_o}, 8'b100);
    chk("n_eoi1_err", {7'd0, eoi_err_o}, 8'd0);
    step(); chk("n_eoi2", {5'd0, in_service_o}, 8'b000);
    step(); chk("n_eoi3_err", {7'd0, eoi_err_o}, 8'd1);
    chk("n_eoi3_is", {5'd0, in_service_o}, 8'b000);
    eoi_i = 1'b0;
    step(); chk("n_err_pulse", {7'd0, eoi_err_o}, 8'd0);

    // Priority blocking and invalid channel with bus 1 in service
    bus_req_i = 3'b010; chan_i = 4'd2;
    step(); step(); ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("b_is010", {5'd0, in_service_o}, 8'b010);
    step(); step(); step();
    chk("b_same_bus", {7'd0, irq_o}, 8'd0);
    bus_req_i = 3'b100; chan_i = 4'd0;
    step(); step(); step();
    chk("b_lower_bus", {7'd0, irq_o}, 8'd0);
    bus_req_i = 3'b001; chan_i = 4'd12;
    step(); step(); step();
    chk("b_bad_chan", {7'd0, irq_o}, 8'd0);
    bus_req_i = '0; eoi_i = 1'b1; step(); eoi_i = 1'b0;
    chk("b_clear", {5'd0, in_service_o}, 8'b000);

    // Timeout: irq high exactly 4 cycles, then re-qualify
    bus_req_i = 3'b001; chan_i = 4'd4;
    step(); step();
    chk("to_rise", {7'd0, irq_o}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold", {6'd0, irq_o, spurious_o}, 8'b10);
    end
    step();
    chk("to_drop", {7'd0, irq_o}, 8'd0);
    chk("to_spur", {7'd0, spurious_o}, 8'd1);
    step();
    chk("to_spur_end", {6'd0, irq_o, spurious_o}, 8'b00);
    step();
    chk("to_requal", {7'd0, irq_o}, 8'd1);
    ack_i = 1'b1; step(); ack_i = 1'b0; bus_req_i = '0;
    chk("to_ack_is", {5'd0, in_service_o}, 8'b001);
    eoi_i = 1'b1; step(); eoi_i = 1'b0;

    // Simultaneous ack and EOI: pop old mask, then push
    bus_req_i = 3'b100; chan_i = 4'd6;
    step(); step(); ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("s_is100", {5'd0, in_service_o}, 8'b100);
    bus_req_i = 3'b001; chan_i = 4'd2;
    step(); step();
    chk("s_vec", {2'd0, vec_o}, 8'b00_0010);
    ack_i = 1'b1; eoi_i = 1'b1; step(); ack_i = 1'b0; eoi_i = 1'b0; bus_req_i = '0;
    chk("s_is001", {5'd0, in_service_o}, 8'b001);
    chk("s_irq", {7'd0, irq_o}, 8'd0);

    // Reset mid-REQ
    eoi_i = 1'b1; step(); eoi_i = 1'b0;
    bus_req_i = 3'b100; chan_i = 4'd1;
    step(); step(); ack_i = 1'b1; step(); ack_i = 1'b0;
    bus_req_i = 3'b010; chan_i = 4'd3;
    step(); step();
    chk("r_irq", {7'd0, irq_o}, 8'd1);
    chk("r_vec", {2'd0, vec_o}, 8'b01_0011);
    chk("r_is", {5'd0, in_service_o}, 8'b100);
    rst = 1'b1; step();
    outs_zero("rst_req");
    rst = 1'b0; bus_req_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
